// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//
// Multi-cycle data memory for the MEM stage of the pipelined CPU. It is a
// byte-addressed, big-endian array. A load or store is accepted from EX/MEM,
// and the pipeline is held through Stall for a fixed latency. The access then
// commits, and RspValid pulses for one cycle. Read data is registered.
//
// Parameters
//   DEPTH_BYTES  memory size in bytes (multiple of 4)
//   LATENCY      wait cycles between acceptance and commit (>= 1)
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   MemRead       load request
//   MemWrite      store request (wins when MemRead is also high)
//   MemAddr       32-bit byte address
//   MemWriteData  32-bit store data
//   MemReadData   registered load data, updated only when a load commits
//   Stall         high while a request is pending (combinational)
//   RspValid      one-cycle completion pulse
//   AddrErr       one-cycle misaligned/out-of-range pulse, with RspValid
// -----------------------------------------------------------------------------
module data_mem_responder #(
  parameter int DEPTH_BYTES = 128,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] MemAddr,
  input  logic [31:0] MemWriteData,
  output logic [31:0] MemReadData,
  output logic        Stall,
  output logic        RspValid,
  output logic        AddrErr
);

  localparam int          CntW     = $clog2(LATENCY) + 1;
  localparam int          IdxW     = $clog2(DEPTH_BYTES);
  localparam logic [31:0] LastWord = 32'(DEPTH_BYTES - 4);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state;
  state_t          stateNext;
  logic [CntW-1:0] cnt;

  // Request captured at acceptance. Later input changes during WAIT do not matter.
  logic [31:0]     addrQ;
  logic [31:0]     dataQ;
  logic            isWriteQ;

  logic [7:0]      mem [DEPTH_BYTES];

  logic            request;
  logic            accept;
  logic            commit;
  logic            addrOk;
  logic [IdxW-1:0] base;
  logic [31:0]     readWord;

  assign request = MemRead | MemWrite;
  assign accept  = (state == IDLE) && request;
  assign commit  = (state == WAIT) && (cnt == '0);

  // The full 32-bit compare keeps a huge address from aliasing back into the array.
  assign addrOk  = (addrQ[1:0] == 2'b00) && (addrQ <= LastWord);

  assign base     = addrQ[IdxW-1:0];
  assign readWord = {mem[base], mem[base + IdxW'(1)],
                     mem[base + IdxW'(2)], mem[base + IdxW'(3)]};

  // NOTE: sequential state uses non-blocking assignments so that every
  // register samples the values from before the edge.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // NOTE: outputs get a default before the case statement, so no path leaves
  // them unassigned and no latch is inferred.
  always_comb begin
    stateNext = state;
    Stall     = 1'b0;
    case (state)
      IDLE: begin
        Stall = request;
        if (request) stateNext = WAIT;
      end
      WAIT: begin
        Stall = 1'b1;
        if (cnt == '0) stateNext = RESP;
      end
      // The request is still on the inputs here, but it belongs to the
      // instruction that has just completed.
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      addrQ    <= MemAddr;
      dataQ    <= MemWriteData;
      isWriteQ <= MemWrite;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      MemReadData <= '0;
      RspValid    <= 1'b0;
      AddrErr     <= 1'b0;
    end else begin
      RspValid <= commit;
      AddrErr  <= commit && !addrOk;

      if (accept)
        cnt <= CntW'(LATENCY - 1);
      else if ((state == WAIT) && (cnt != '0))
        cnt <= cnt - CntW'(1);

      // A simultaneous read and write counts as a write, so the read data is kept.
      if (commit && !isWriteQ)
        MemReadData <= addrOk ? readWord : '0;
    end
  end

  // NOTE: the array has no reset. Its contents survive rst, and a reset
  // sampled on the commit edge blocks the write and aborts the store.
  always_ff @(posedge clk) begin
    if (!rst && commit && isWriteQ && addrOk) begin
      mem[base]              <= dataQ[31:24];
      mem[base + IdxW'(1)]   <= dataQ[23:16];
      mem[base + IdxW'(2)]   <= dataQ[15:8];
      mem[base + IdxW'(3)]   <= dataQ[7:0];
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_data_mem_responder
//
// Drives directed and random load/store transactions into data_mem_responder.
// Every cycle, the DUT outputs are compared with a transaction-level model:
// a byte array, a fixed stall window of LATENCY+1 cycles, and then a single
// response cycle.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

  localparam int DEPTH_BYTES = 128;
  localparam int LATENCY     = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] MemAddr;
  logic [31:0] MemWriteData;
  logic [31:0] MemReadData;
  logic        Stall;
  logic        RspValid;
  logic        AddrErr;

  data_mem_responder #(
    .DEPTH_BYTES (DEPTH_BYTES),
    .LATENCY     (LATENCY)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .MemAddr      (MemAddr),
    .MemWriteData (MemWriteData),
    .MemReadData  (MemReadData),
    .Stall        (Stall),
    .RspValid     (RspValid),
    .AddrErr      (AddrErr)
  );

  always #5 clk = ~clk;

  int nChecks    = 0;
  int nErrors    = 0;
  int stallCount = 0;
  int s0;

  // Reference model: the byte array, plus the expected outputs for the current cycle.
  logic [7:0]  m [DEPTH_BYTES];
  logic        expStall = 1'b0;
  logic        expRsp   = 1'b0;
  logic        expErr   = 1'b0;
  logic [31:0] expData  = 32'h0;
  bit          checkEn  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit modelOk(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (({32'd0, a} + 64'd4) <= 64'(DEPTH_BYTES));
  endfunction

  function automatic logic [31:0] modelWord(input logic [31:0] a);
    int i;
    i = int'(a);
    return {m[i], m[i+1], m[i+2], m[i+3]};
  endfunction

  // Applies one access to the model at its commit edge.
  task automatic modelCommit(input logic rd, input logic wr, input logic [31:0] a,
                             input logic [31:0] d);
    bit ok;
    ok     = modelOk(a);
    expErr = !ok;
    if (ok) begin
      if (wr) begin
        for (int k = 0; k < 4; k++) m[int'(a) + k] = d[31 - 8*k -: 8];
      end else if (rd) begin
        expData = modelWord(a);
      end
    end else if (!wr) begin
      expData = 32'h0;
    end
  endtask

  // Per-cycle comparison against the model, on the falling edge.
  always @(negedge clk) begin
    if (Stall === 1'b1) stallCount++;
    if (checkEn) begin
      check("Stall",       32'(Stall),    32'(expStall));
      check("RspValid",    32'(RspValid), 32'(expRsp));
      check("AddrErr",     32'(AddrErr),  32'(expErr));
      check("MemReadData", MemReadData,   expData);
    end
  end

  // Drives each cycle's inputs 1ns after the rising edge.
  task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    MemRead = rd; MemWrite = wr; MemAddr = a; MemWriteData = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      expStall = 1'b0; expRsp = 1'b0; expErr = 1'b0;
    end
  endtask

  // One complete access. Returns 1ns into the response cycle, with the request still held.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input bit scramble);
    @(posedge clk); #1;
    drive(rd, wr, a, d);
    expStall = 1'b1; expRsp = 1'b0; expErr = 1'b0;
    for (int i = 0; i < LATENCY; i++) begin
      @(posedge clk); #1;
      if (scramble) begin
        MemAddr      = $urandom;
        MemWriteData = $urandom;
      end
    end
    @(posedge clk); #1;
    modelCommit(rd, wr, a, d);
    expStall = 1'b0; expRsp = 1'b1;
  endtask

  // A store that is killed by rst, held high during wait cycle rstCycle (1..LATENCY).
  task automatic storeAbort(input logic [31:0] a, input logic [31:0] d, input int rstCycle);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, a, d);
    expStall = 1'b1; expRsp = 1'b0; expErr = 1'b0;
    for (int i = 1; i <= rstCycle; i++) begin
      @(posedge clk); #1;
      if (i == rstCycle) rst = 1'b1;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    expStall = 1'b0; expRsp = 1'b0; expErr = 1'b0; expData = 32'h0;
    #1;
    check("abort_stall", 32'(Stall), 32'h0);
    check("abort_rdata", MemReadData, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    logic        rd;
    logic        wr;
    int          r;

    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("reset_stall",    32'(Stall),    32'h0);
    check("reset_rspvalid", 32'(RspValid), 32'h0);
    check("reset_addrerr",  32'(AddrErr),  32'h0);
    check("reset_rdata",    MemReadData,   32'h0);
    checkEn = 1'b1;

    // Fill the whole array. A few words hold known values for the directed cases.
    for (int w = 0; w < DEPTH_BYTES / 4; w++) begin
      case (w * 4)
        4:       d = 32'h44444444;
        12:      d = 32'h0C0C0C0C;
        16:      d = 32'h11111111;
        20:      d = 32'h20202020;
        default: d = $urandom;
      endcase
      access(1'b0, 1'b1, 32'(w * 4), d, 1'b0);
    end
    idle(1);

    // Write then read: the word is stored big-endian, with LATENCY+1 stall cycles each way.
    s0 = stallCount;
    access(1'b0, 1'b1, 32'd8, 32'hDEADBEEF, 1'b0);
    idle(1);
    check("store8_stall_cycles", 32'(stallCount - s0), 32'(LATENCY + 1));
    check("mem8",  32'(dut.mem[8]),  32'hDE);
    check("mem9",  32'(dut.mem[9]),  32'hAD);
    check("mem10", 32'(dut.mem[10]), 32'hBE);
    check("mem11", 32'(dut.mem[11]), 32'hEF);
    s0 = stallCount;
    access(1'b1, 1'b0, 32'd8, 32'h0, 1'b0);
    #1;
    check("load8_rspvalid", 32'(RspValid), 32'h1);
    check("load8_data", MemReadData, 32'hDEADBEEF);
    idle(1);
    check("load8_stall_cycles", 32'(stallCount - s0), 32'(LATENCY + 1));

    // A misaligned store leaves the array unchanged and raises AddrErr.
    access(1'b0, 1'b1, 32'd6, 32'h12345678, 1'b0);
    #1;
    check("mis_addrerr", 32'(AddrErr), 32'h1);
    check("mis_rspvalid", 32'(RspValid), 32'h1);
    access(1'b1, 1'b0, 32'd4, 32'h0, 1'b0);
    #1;
    check("mis_load4", MemReadData, 32'h44444444);
    access(1'b1, 1'b0, 32'd8, 32'h0, 1'b0);
    #1;
    check("mis_load8", MemReadData, 32'hDEADBEEF);

    // Out-of-range loads, then the last valid word.
    access(1'b1, 1'b0, 32'd128, 32'h0, 1'b0);
    #1;
    check("oor_data", MemReadData, 32'h0);
    check("oor_addrerr", 32'(AddrErr), 32'h1);
    access(1'b1, 1'b0, 32'd124, 32'h0, 1'b0);
    #1;
    check("last_addrerr", 32'(AddrErr), 32'h0);
    check("last_data", MemReadData, modelWord(32'd124));
    access(1'b1, 1'b0, 32'hFFFFFFFC, 32'h0, 1'b0);
    #1;
    check("huge_addrerr", 32'(AddrErr), 32'h1);
    check("huge_data", MemReadData, 32'h0);
    idle(2);

    // A reset in the first wait cycle, and a reset on the commit edge, both abort the store.
    storeAbort(32'd12, 32'hCAFEF00D, 1);
    access(1'b1, 1'b0, 32'd12, 32'h0, 1'b0);
    #1;
    check("abort1_load12", MemReadData, 32'h0C0C0C0C);
    storeAbort(32'd20, 32'hBAD0BAD0, LATENCY);
    access(1'b1, 1'b0, 32'd20, 32'h0, 1'b0);
    #1;
    check("abortc_load20", MemReadData, 32'h20202020);

    // A reset in the response cycle comes after the commit, so the store has landed.
    access(1'b0, 1'b1, 32'd24, 32'h55AA55AA, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    expStall = 1'b0; expRsp = 1'b0; expErr = 1'b0; expData = 32'h0;
    access(1'b1, 1'b0, 32'd24, 32'h0, 1'b0);
    #1;
    check("resp_rst_load24", MemReadData, 32'h55AA55AA);

    // A simultaneous read and write acts as a write. The next load follows with no gap.
    access(1'b1, 1'b0, 32'd16, 32'h0, 1'b0);
    access(1'b1, 1'b1, 32'd0, 32'h0A0B0C0D, 1'b0);
    #1;
    check("both_keeps_rdata", MemReadData, 32'h11111111);
    check("mem0", 32'(dut.mem[0]), 32'h0A);
    access(1'b1, 1'b0, 32'd0, 32'h0, 1'b0);
    #1;
    check("b2b_load0", MemReadData, 32'h0A0B0C0D);

    // Random traffic: mixed ops and addresses, inputs scrambled during WAIT, random gaps.
    for (int n = 0; n < 300; n++) begin
      r = int'($urandom_range(0, 9));
      if (r <= 5)      a = {25'd0, 5'($urandom_range(0, 31)), 2'b00};
      else if (r == 6) a = {25'd0, 7'($urandom_range(0, 127))};
      else if (r == 7) a = 32'($urandom_range(32, 40) * 4);
      else if (r == 8) a = $urandom;
      else begin
        case ($urandom_range(0, 4))
          0:       a = 32'd124;
          1:       a = 32'd125;
          2:       a = 32'd128;
          3:       a = 32'd132;
          default: a = 32'hFFFFFFFC;
        endcase
      end
      case ($urandom_range(0, 3))
        0, 1:    begin rd = 1'b1; wr = 1'b0; end
        2:       begin rd = 1'b0; wr = 1'b1; end
        default: begin rd = 1'b1; wr = 1'b1; end
      endcase
      access(rd, wr, a, $urandom, 1'($urandom_range(0, 1)));
      idle(int'($urandom_range(0, 2)));
    end
    idle(2);

    checkEn = 1'b0;
    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
